config_reg_bank: RTL and testbench

Parametrised configuration register bank for a tile core. It generalises a fixed two-register config block to NUM_REGS registers at a programmable base address. It adds:
- double-buffered (shadow/active) storage with a commit strobe;
- registered read-back with a valid flag;
- out-of-range error reporting.

It sits between the tile config bus and core datapath logic. Only active values drive the core.

---
 rtl/cfg_reg_pkg.sv | 36 +++
 rtl/cfg_reg_slot.sv | 29 ++
 rtl/config_reg_bank.sv | 97 +++++++++
 tb/tb_config_reg_bank.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cfg_reg_pkg.sv
// Shared types, default widths and the address decode for config_reg_bank.
// Optional feature macro used by the top: CONFIG_REG_LOCK_EN.
package cfg_reg_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 8;
  // Decode is done at a fixed 32-bit width; callers mask down to ADDR_WIDTH.
  localparam int DEC_W = 32;

  // One shadow/active register pair at the default data width.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] shadow;
    logic [DEF_DATA_WIDTH-1:0] active;
  } cfg_pair_t;

  // Result of an address decode.
  typedef struct packed {
    logic             in_range;
    logic [DEC_W-1:0] idx;
  } cfg_dec_t;

  // idx wraps at aw bits; in_range also requires addr >= base so a wrapped
  // subtraction below the window never aliases onto a real register.
  function automatic cfg_dec_t cfg_decode(input logic [DEC_W-1:0] addr,
                                          input logic [DEC_W-1:0] base,
                                          input int unsigned      num,
                                          input int unsigned      aw);
    cfg_dec_t         d;
    logic [DEC_W-1:0] mask;
    mask       = (aw >= DEC_W) ? '1 : ((DEC_W'(1) << aw) - DEC_W'(1));
    d.idx      = (addr - base) & mask;
    d.in_range = (addr >= base) && (d.idx < DEC_W'(num));
    return d;
  endfunction

endpackage

// File: rtl/cfg_reg_slot.sv
// One shadow/active config register pair. Writes land in shadow; commit
// copies shadow to active, taking a same-cycle write straight through.
module cfg_reg_slot
  import cfg_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  commit,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] shadow_q,
  output logic [DATA_WIDTH-1:0] active_q
);

  // Shadow takes writes; active follows shadow (or the new write) on commit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_q <= RESET_VALUE;
      active_q <= RESET_VALUE;
    end else begin
      if (wr_en)  shadow_q <= wr_data;
      if (commit) active_q <= wr_en ? wr_data : shadow_q;
    end
  end

endmodule

// File: rtl/config_reg_bank.sv
// Double-buffered config register bank at a programmable base address with
// registered read-back and out-of-range error pulse.
// Define CONFIG_REG_LOCK_EN to add a config_lock input that blocks writes
// (flagged as errors) and commits while held high.
module config_reg_bank
  import cfg_reg_pkg::*;
#(
  parameter int                    NUM_REGS    = 4,
  parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          config_addr,
  input  logic [DATA_WIDTH-1:0]          config_data,
  input  logic                           config_write,
  input  logic                           config_read,
  input  logic                           commit,
`ifdef CONFIG_REG_LOCK_EN
  input  logic                           config_lock,
`endif
  output logic [DATA_WIDTH-1:0]          read_config_data,
  output logic                           read_valid,
  output logic                           config_err,
  output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_out
);

  logic                  lock;
  cfg_dec_t              dec;
  logic                  wr_ok, commit_ok, err_d;
  logic [NUM_REGS-1:0]   wr_en;
  logic [DATA_WIDTH-1:0] shadow [NUM_REGS];
  logic [DATA_WIDTH-1:0] active [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;
  logic                  rd_valid_q, err_q;

`ifdef CONFIG_REG_LOCK_EN
  assign lock = config_lock;
`else
  assign lock = 1'b0;
`endif

  assign dec       = cfg_decode(DEC_W'(config_addr), DEC_W'(BASE_ADDR),
                                unsigned'(NUM_REGS), unsigned'(ADDR_WIDTH));
  assign wr_ok     = config_write && dec.in_range && !lock;
  assign commit_ok = commit && !lock;
  // Any rejected access (bad address, or a write while locked) flags once.
  assign err_d     = (config_write && (!dec.in_range || lock)) ||
                     (config_read && !dec.in_range);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
    assign wr_en[i] = wr_ok && (dec.idx == DEC_W'(i));

    cfg_reg_slot #(
      .DATA_WIDTH  (DATA_WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_slot (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en[i]),
      .commit   (commit_ok),
      .wr_data  (config_data),
      .shadow_q (shadow[i]),
      .active_q (active[i])
    );

    assign cfg_out[i*DATA_WIDTH +: DATA_WIDTH] = active[i];
  end

  // Read mux over pre-edge shadow values; out-of-range reads return zero.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (dec.in_range && (dec.idx == DEC_W'(i))) rd_data_d = shadow[i];
    end
  end

  // Read-back and error pulse registers; data holds between reads.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= config_read;
      err_q      <= err_d;
      if (config_read) rd_data_q <= rd_data_d;
    end
  end

  assign read_config_data = rd_data_q;
  assign read_valid       = rd_valid_q;
  assign config_err       = err_q;

endmodule

// File: tb/tb_config_reg_bank.sv
// Self-checking bench for config_reg_bank: directed scenarios plus a random
// run, all checked against an array-based model of the register bank.
module tb_config_reg_bank;

  localparam int          NR   = 4;
  localparam int          DW   = 32;
  localparam int          AW   = 8;
  localparam logic [7:0]  BASE = 8'h10;
  localparam logic [31:0] RV   = 32'hA5A5A5A5;

  logic           clk = 1'b0;
  logic           reset;
  logic [AW-1:0]  config_addr;
  logic [DW-1:0]  config_data;
  logic           config_write, config_read, commit;
  logic           config_lock = 1'b0;
  logic [DW-1:0]  read_config_data;
  logic           read_valid, config_err;
  logic [NR*DW-1:0] cfg_out;

  int pass = 0;
  int total = 0;

  // Reference model state
  logic [31:0] sh [NR];
  logic [31:0] act [NR];
  logic        m_rv, m_err;
  logic [31:0] m_rd;

  always #5 clk = ~clk;

  config_reg_bank #(
    .NUM_REGS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .BASE_ADDR(BASE), .RESET_VALUE(RV)
  ) dut (
    .clk(clk), .reset(reset), .config_addr(config_addr),
    .config_data(config_data), .config_write(config_write),
    .config_read(config_read), .commit(commit),
`ifdef CONFIG_REG_LOCK_EN
    .config_lock(config_lock),
`endif
    .read_config_data(read_config_data), .read_valid(read_valid),
    .config_err(config_err), .cfg_out(cfg_out)
  );

  function automatic logic [NR*DW-1:0] exp_cfg();
    logic [NR*DW-1:0] v;
    for (int j = 0; j < NR; j++) v[j*DW +: DW] = act[j];
    return v;
  endfunction

  // Drive one bus cycle (called at a falling edge), advance the model across
  // the rising edge, and return at the next falling edge for sampling.
  task automatic step(input bit w, input bit r, input bit c,
                      input logic [7:0] a, input logic [31:0] d);
    int  k;
    bit  ok, wr_eff;
    config_write = w; config_read = r; commit = c;
    config_addr = a; config_data = d;
    @(posedge clk);
    if (!reset) begin
      for (int j = 0; j < NR; j++) begin sh[j] = RV; act[j] = RV; end
      m_rv = 0; m_rd = 0; m_err = 0;
    end else begin
      k      = int'(a) - int'(BASE);
      ok     = (k >= 0) && (k < NR);
      wr_eff = w && ok && !config_lock;
      m_rv   = r;
      if (r) m_rd = ok ? sh[k] : 32'h0;
      m_err  = (w && (!ok || config_lock)) || (r && !ok);
      if (c && !config_lock) begin
        for (int j = 0; j < NR; j++) act[j] = sh[j];
        if (wr_eff) act[k] = d;
      end
      if (wr_eff) sh[k] = d;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 8'h00, 32'h0);
  endtask

  task automatic test_reset();
    reset = 0;
    step(1, 1, 1, BASE, 32'h1111_2222);
    step(0, 0, 0, 8'h00, 32'h0);
    for (int j = 0; j < NR; j++) begin
      total++;
      if (cfg_out[j*DW +: DW] !== 32'hA5A5A5A5)
        $display("FAIL reset_cfg[%0d] got=%h exp=%h", j, cfg_out[j*DW +: DW], 32'hA5A5A5A5);
      else pass++;
    end
    total++; if (read_valid !== 1'b0) $display("FAIL reset_rv got=%b exp=0", read_valid); else pass++;
    total++; if (config_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", config_err); else pass++;
    total++; if (read_config_data !== 32'h0) $display("FAIL reset_rd got=%h exp=0", read_config_data); else pass++;
    reset = 1;
  endtask

  task automatic test_shadow_commit();
    step(1, 0, 0, BASE + 8'd2, 32'h12345678);
    total++; if (cfg_out[95:64] !== RV) $display("FAIL sc_nocommit got=%h exp=%h", cfg_out[95:64], RV); else pass++;
    step(0, 1, 0, BASE + 8'd2, 32'h0);
    total++; if (read_valid !== 1'b1) $display("FAIL sc_rv got=%b exp=1", read_valid); else pass++;
    total++; if (read_config_data !== 32'h12345678) $display("FAIL sc_rd got=%h exp=12345678", read_config_data); else pass++;
    step(0, 0, 1, 8'h00, 32'h0);
    total++; if (cfg_out[95:64] !== 32'h12345678) $display("FAIL sc_commit got=%h exp=12345678", cfg_out[95:64]); else pass++;
    total++; if (cfg_out !== exp_cfg()) $display("FAIL sc_cfg got=%h exp=%h", cfg_out, exp_cfg()); else pass++;
  endtask

  task automatic test_write_through();
    step(1, 0, 1, BASE + 8'd1, 32'hDEADBEEF);
    total++; if (cfg_out[63:32] !== 32'hDEADBEEF) $display("FAIL wt_cfg1 got=%h exp=deadbeef", cfg_out[63:32]); else pass++;
    total++; if (cfg_out[95:64] !== 32'h12345678) $display("FAIL wt_cfg2 got=%h exp=12345678", cfg_out[95:64]); else pass++;
  endtask

  task automatic test_out_of_range();
    step(1, 0, 0, 8'h14, 32'h5555_5555);
    total++; if (config_err !== 1'b1) $display("FAIL oor_wr_err got=%b exp=1", config_err); else pass++;
    total++; if (cfg_out !== exp_cfg()) $display("FAIL oor_wr_cfg got=%h exp=%h", cfg_out, exp_cfg()); else pass++;
    idle();
    total++; if (config_err !== 1'b0) $display("FAIL oor_err_pulse got=%b exp=0", config_err); else pass++;
    step(0, 1, 0, 8'h0F, 32'h0);
    total++; if (read_valid !== 1'b1) $display("FAIL oor_rd_rv got=%b exp=1", read_valid); else pass++;
    total++; if (read_config_data !== 32'h0) $display("FAIL oor_rd_data got=%h exp=0", read_config_data); else pass++;
    total++; if (config_err !== 1'b1) $display("FAIL oor_rd_err got=%b exp=1", config_err); else pass++;
  endtask

  task automatic test_same_cycle_rw();
    step(1, 0, 0, BASE, 32'h1);
    step(1, 1, 0, BASE, 32'h2);
    total++; if (read_config_data !== 32'h1) $display("FAIL rw_old got=%h exp=1", read_config_data); else pass++;
    step(0, 1, 0, BASE, 32'h0);
    total++; if (read_config_data !== 32'h2) $display("FAIL rw_new got=%h exp=2", read_config_data); else pass++;
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < NR; j++) begin
      step(0, 1, 0, BASE + 8'(j), 32'h0);
      total++; if (read_valid !== 1'b1) $display("FAIL b2b_rv[%0d] got=%b exp=1", j, read_valid); else pass++;
      total++; if (read_config_data !== m_rd) $display("FAIL b2b_rd[%0d] got=%h exp=%h", j, read_config_data, m_rd); else pass++;
    end
    idle();
    total++; if (read_valid !== 1'b0) $display("FAIL b2b_idle_rv got=%b exp=0", read_valid); else pass++;
    total++; if (read_config_data !== m_rd) $display("FAIL b2b_hold got=%h exp=%h", read_config_data, m_rd); else pass++;
  endtask

`ifdef CONFIG_REG_LOCK_EN
  task automatic test_lock();
    config_lock = 1;
    step(1, 0, 1, BASE, 32'hFF);
    total++; if (config_err !== 1'b1) $display("FAIL lock_err got=%b exp=1", config_err); else pass++;
    total++; if (cfg_out !== exp_cfg()) $display("FAIL lock_cfg got=%h exp=%h", cfg_out, exp_cfg()); else pass++;
    step(0, 1, 0, BASE, 32'h0);
    total++; if (read_config_data !== m_rd || read_config_data === 32'hFF)
      $display("FAIL lock_rd got=%h exp=%h", read_config_data, m_rd); else pass++;
    config_lock = 0;
  endtask
`endif

  task automatic test_mid_reset();
    step(1, 0, 0, BASE + 8'd3, 32'hCAFE_0003);
    reset = 0;
    step(1, 1, 1, 8'h0F, 32'h0BAD_0BAD);
    total++; if (read_valid !== 1'b0) $display("FAIL mrst_rv got=%b exp=0", read_valid); else pass++;
    total++; if (config_err !== 1'b0) $display("FAIL mrst_err got=%b exp=0", config_err); else pass++;
    total++; if (cfg_out !== {NR{RV}}) $display("FAIL mrst_cfg got=%h exp=%h", cfg_out, {NR{RV}}); else pass++;
    reset = 1;
    step(0, 1, 0, BASE + 8'd3, 32'h0);
    total++; if (read_config_data !== RV) $display("FAIL mrst_rd got=%h exp=%h", read_config_data, RV); else pass++;
  endtask

  task automatic test_random();
    logic [7:0]  a;
    logic [31:0] d;
    bit          w, r, c;
    for (int n = 0; n < 400; n++) begin
      w = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 1) == 1);
      c = ($urandom_range(0, 3) == 0);
      a = BASE - 8'd2 + 8'($urandom_range(0, NR + 3));
      d = $urandom();
`ifdef CONFIG_REG_LOCK_EN
      config_lock = ($urandom_range(0, 7) == 0);
`endif
      step(w, r, c, a, d);
      total++; if (read_valid !== m_rv) $display("FAIL rand_rv n=%0d got=%b exp=%b", n, read_valid, m_rv); else pass++;
      total++; if (read_config_data !== m_rd) $display("FAIL rand_rd n=%0d got=%h exp=%h", n, read_config_data, m_rd); else pass++;
      total++; if (config_err !== m_err) $display("FAIL rand_err n=%0d got=%b exp=%b", n, config_err, m_err); else pass++;
      total++; if (cfg_out !== exp_cfg()) $display("FAIL rand_cfg n=%0d got=%h exp=%h", n, cfg_out, exp_cfg()); else pass++;
    end
    config_lock = 0;
  endtask

  initial begin
    reset = 0; config_addr = '0; config_data = '0;
    config_write = 0; config_read = 0; commit = 0;
    m_rv = 0; m_rd = 0; m_err = 0;
    for (int j = 0; j < NR; j++) begin sh[j] = RV; act[j] = RV; end
    @(negedge clk);
    test_reset();
    test_shadow_commit();
    test_write_through();
    test_out_of_range();
    test_same_cycle_rw();
    test_back_to_back();
`ifdef CONFIG_REG_LOCK_EN
    test_lock();
`endif
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
